// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, flag layout and counter width.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLTU = 3'd6,
    ALU_NOR  = 3'd7
  } alu_control_t;

  localparam int FLAGS_W    = 4;
  localparam int OP_COUNT_W = 16;

  // Flag vector layout is {N, Z, C, V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu.sv
// Combinational ALU: eight operations, {N,Z,C,V} flags. C/V are only meaningful
// for ADD/SUB (C = no-borrow on subtract) and read 0 for every other operation.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [2:0]         alu_control,
  output logic [FLAGS_W-1:0] flags,
  output logic [WIDTH-1:0]   result
);

  alu_control_t     ctl;
  logic             is_sub;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH:0]   sum_ext;
  logic             ovf;
  logic             carry;
  logic             vflag;

  assign ctl = alu_control_t'(alu_control);

  // Compares share the subtractor so SLT/SLTU come from its sign/carry.
  always_comb begin
    is_sub  = (ctl == ALU_SUB) || (ctl == ALU_SLT) || (ctl == ALU_SLTU);
    b_in    = is_sub ? ~op2 : op2;
    sum_ext = {1'b0, op1} + {1'b0, b_in} + {{WIDTH{1'b0}}, is_sub};
    ovf     = (op1[WIDTH-1] == b_in[WIDTH-1]) && (sum_ext[WIDTH-1] != op1[WIDTH-1]);
  end

  always_comb begin
    result = '0;
    carry  = 1'b0;
    vflag  = 1'b0;
    case (ctl)
      ALU_ADD, ALU_SUB: begin
        result = sum_ext[WIDTH-1:0];
        carry  = sum_ext[WIDTH];
        vflag  = ovf;
      end
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_XOR:  result = op1 ^ op2;
      ALU_SLT:  result = WIDTH'(sum_ext[WIDTH-1] ^ ovf);
      ALU_SLTU: result = WIDTH'(!sum_ext[WIDTH]);
      ALU_NOR:  result = ~(op1 | op2);
      default:  result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = vflag;
  end

endmodule

// File: rtl/alu_exec_stage.sv
// One-entry registered ALU execute stage with valid/ready handshake, flag register
// and accept counter. Define ALU_EXEC_FWD_EN to add result-forwarding selects.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_op1,
  input  logic [WIDTH-1:0]      in_op2,
  input  logic [2:0]            in_alu_control,
  input  logic                  in_set_flags,
`ifdef ALU_EXEC_FWD_EN
  input  logic                  in_fwd_a,
  input  logic                  in_fwd_b,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [FLAGS_W-1:0]    out_flags,
  output logic [FLAGS_W-1:0]    flags_q,
  output logic [OP_COUNT_W-1:0] op_count
);

  logic               accept;
  logic               drain;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH-1:0]   alu_result;
  logic [FLAGS_W-1:0] alu_flags;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

`ifdef ALU_EXEC_FWD_EN
  // Forwarding takes the output register as-is, even if it was already drained.
  assign alu_a = in_fwd_a ? out_result : in_op1;
  assign alu_b = in_fwd_b ? out_result : in_op2;
`else
  assign alu_a = in_op1;
  assign alu_b = in_op2;
`endif

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op1        (alu_a),
    .op2        (alu_b),
    .alu_control(in_alu_control),
    .flags      (alu_flags),
    .result     (alu_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      flags_q    <= '0;
      op_count   <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_flags  <= alu_flags;
      op_count   <= op_count + OP_COUNT_W'(1);
      if (in_set_flags) begin
        flags_q <= alu_flags;
      end
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed + randomized bench for alu_exec_stage at WIDTH=4 against an arithmetic reference.
module tb_alu_exec_stage;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_op1;
  logic [W-1:0] in_op2;
  logic [2:0]   in_alu_control;
  logic         in_set_flags;
`ifdef ALU_EXEC_FWD_EN
  logic         in_fwd_a;
  logic         in_fwd_b;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic [3:0]   flags_q;
  logic [15:0]  op_count;

  int checks = 0;
  int errors = 0;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op1        (in_op1),
    .in_op2        (in_op2),
    .in_alu_control(in_alu_control),
    .in_set_flags  (in_set_flags),
`ifdef ALU_EXEC_FWD_EN
    .in_fwd_a      (in_fwd_a),
    .in_fwd_b      (in_fwd_b),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_flags     (out_flags),
    .flags_q       (flags_q),
    .op_count      (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: returns {result[3:0], N, Z, C, V}; ops 0..7 = add sub and or xor slt sltu nor.
  function automatic logic [7:0] ref_alu(input int ctl, input int a, input int b);
    int sa, sb, r, full;
    bit n, z, c, v;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    c = 0;
    v = 0;
    case (ctl)
      0: begin full = a + b; r = full % 16; c = (full >= 16); v = (sa + sb > 7) || (sa + sb < -8); end
      1: begin full = a - b; r = (full + 16) % 16; c = (a >= b); v = (sa - sb > 7) || (sa - sb < -8); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (sa < sb) ? 1 : 0;
      6: r = (a < b) ? 1 : 0;
      default: r = (~(a | b)) & 15;
    endcase
    n = (r >= 8);
    z = (r == 0);
    return {r[3:0], n, z, c, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int a, input int b, input int ctl, input bit sf);
    in_valid       = v;
    in_op1         = W'(a);
    in_op2         = W'(b);
    in_alu_control = 3'(ctl);
    in_set_flags   = sf;
  endtask

  logic [7:0] e;
  logic [7:0] e2;
  logic [7:0] q[$];
  logic [3:0] exp_fq;
  int         exp_cnt;
  bit         mrdy;
  bit         acc;

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    drive(0, 0, 0, 0, 0);
`ifdef ALU_EXEC_FWD_EN
    in_fwd_a = 1'b0;
    in_fwd_b = 1'b0;
`endif
    #2;
    check("rst_vld", 32'(out_valid), 0);
    check("rst_res", 32'(out_result), 0);
    check("rst_flags", 32'(out_flags), 0);
    check("rst_fq", 32'(flags_q), 0);
    check("rst_cnt", 32'(op_count), 0);
    check("rst_rdy", 32'(in_ready), 1);
    tick();
    reset = 1'b0;
    #1;
    exp_cnt = 0;

    // Sweep all operations back-to-back on 0111 / 0001.
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive(1, 7, 1, c, 0);
      tick();
      e = ref_alu(c, 7, 1);
      exp_cnt++;
      check($sformatf("sweep_vld_%0d", c), 32'(out_valid), 1);
      check($sformatf("sweep_res_%0d", c), 32'(out_result), 32'(e[7:4]));
      check($sformatf("sweep_flg_%0d", c), 32'(out_flags), 32'(e[3:0]));
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check("sweep_drained", 32'(out_valid), 0);
    check("sweep_cnt", 32'(op_count), 32'(exp_cnt));
    check("sweep_fq_hold", 32'(flags_q), 0);

    // Backpressure: hold 1101+0111 for 3 cycles, then back-to-back transfer.
    out_ready = 1'b0;
    drive(1, 13, 7, 0, 0);
    tick();
    exp_cnt++;
    e = ref_alu(0, 13, 7);
    drive(1, 2, 3, 1, 0);
    e2 = ref_alu(1, 2, 3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy", 32'(in_ready), 0);
      check("bp_vld", 32'(out_valid), 1);
      check("bp_res", 32'(out_result), 32'(e[7:4]));
      check("bp_flg", 32'(out_flags), 32'(e[3:0]));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_rdy_up", 32'(in_ready), 1);
    tick();
    exp_cnt++;
    check("b2b_vld", 32'(out_valid), 1);
    check("b2b_res", 32'(out_result), 32'(e2[7:4]));
    check("b2b_flg", 32'(out_flags), 32'(e2[3:0]));
    drive(0, 0, 0, 0, 0);
    tick();
    check("b2b_drained", 32'(out_valid), 0);
    check("b2b_cnt", 32'(op_count), 32'(exp_cnt));

    // Flag commit only on set_flags.
    drive(1, 5, 5, 2, 1);
    tick();
    drive(1, 15, 1, 0, 0);
    tick();
    exp_cnt += 2;
    drive(0, 0, 0, 0, 0);
    tick();
    e = ref_alu(2, 5, 5);
    exp_fq = e[3:0];
    check("fq_commit", 32'(flags_q), 32'(exp_fq));
    e2 = ref_alu(0, 15, 1);
    check("fq_last_flags", 32'(out_flags), 32'(e2[3:0]));

    // Randomized traffic against a one-deep scoreboard.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("rnd_vld", 32'(out_valid), 32'(q.size() != 0));
      mrdy = (q.size() == 0) || out_ready;
      check("rnd_rdy", 32'(in_ready), 32'(mrdy));
      if (out_ready && q.size() != 0) begin
        e = q.pop_front();
        check("rnd_res", 32'(out_result), 32'(e[7:4]));
        check("rnd_flg", 32'(out_flags), 32'(e[3:0]));
      end
      acc = in_valid && mrdy;
      if (acc) begin
        e = ref_alu(int'(in_alu_control), int'(in_op1), int'(in_op2));
        q.push_back(e);
        exp_cnt = (exp_cnt + 1) % 65536;
        if (in_set_flags) exp_fq = e[3:0];
      end
      tick();
      check("rnd_fq", 32'(flags_q), 32'(exp_fq));
      check("rnd_cnt", 32'(op_count), 32'(exp_cnt));
    end

    // Reset mid-operation with an undrained result.
    out_ready = 1'b0;
    drive(1, 9, 9, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    check("mid_pre_vld", 32'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("mid_vld", 32'(out_valid), 0);
    check("mid_res", 32'(out_result), 0);
    check("mid_fq", 32'(flags_q), 0);
    check("mid_cnt", 32'(op_count), 0);
    check("mid_rdy", 32'(in_ready), 1);
    tick();
    check("mid_hold_vld", 32'(out_valid), 0);
    reset = 1'b0;
    #1;
    out_ready = 1'b1;
    drive(1, 3, 4, 0, 0);
    tick();
    check("post_rst_vld", 32'(out_valid), 1);
    check("post_rst_res", 32'(out_result), 7);
    check("post_rst_cnt", 32'(op_count), 1);
    exp_cnt = 1;

`ifdef ALU_EXEC_FWD_EN
    // out_result is now 0111 from the add above.
    drive(1, 0, 1, 0, 0);
    in_fwd_a = 1'b1;
    tick();
    e = ref_alu(0, 7, 1);
    check("fwd_a_res", 32'(out_result), 32'(e[7:4]));
    check("fwd_a_flg", 32'(out_flags), 32'(e[3:0]));
    in_fwd_a = 1'b0;
    in_fwd_b = 1'b1;
    drive(1, 2, 0, 1, 0);
    tick();
    e2 = ref_alu(1, 2, int'(e[7:4]));
    check("fwd_b_res", 32'(out_result), 32'(e2[7:4]));
    in_fwd_b = 1'b0;
    drive(1, 1, 15, 0, 0);
    tick();
    in_fwd_a = 1'b1;
    drive(1, 0, 0, 3, 0);
    tick();
    check("fwd_a_zero", 32'(out_result), 0);
    in_fwd_a = 1'b0;
    exp_cnt += 4;
`endif

    // Counter wrap: drive up to FFFF, then one more accept.
    drive(1, 1, 1, 0, 0);
    repeat (65535 - exp_cnt) tick();
    check("wrap_ffff", 32'(op_count), 32'h0000_FFFF);
    tick();
    check("wrap_zero", 32'(op_count), 0);
    drive(0, 0, 0, 0, 0);
    tick();
    check("wrap_drained", 32'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width passed to the alu instance.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream holds a valid operation.
REQ-005 SHALL have port in_ready  output  1  stage can accept an operation this cycle.
REQ-006 SHALL have port in_op1  input  WIDTH  first operand.
REQ-007 SHALL have port in_op2  input  WIDTH  second operand.
REQ-008 SHALL have port in_alu_control  input  3  alu operation select, passed unmodified to the alu.
REQ-009 SHALL have port in_set_flags  input  1  on accept, commit the alu flags to flags_q.
REQ-010 SHALL have port out_valid  output  1  registered result available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-012 SHALL have port out_result  output  WIDTH  registered alu result.
REQ-013 SHALL have port out_flags  output  4  registered alu flags of the same operation.
REQ-014 SHALL have port flags_q  output  4  architectural flag register.
REQ-015 SHALL have port op_count  output  16  count of accepted operations.

Function
REQ-016 SHALL drive in_ready = !out_valid || out_ready, combinationally.
REQ-017 SHALL define accept as in_valid && in_ready, and drain as out_valid && out_ready.
REQ-018 On accept, SHALL register the alu result into out_result and the alu flags into out_flags, and SHALL set out_valid, giving 1-cycle latency.
REQ-019 On drain without accept, SHALL clear out_valid and hold out_result/out_flags.
REQ-020 On a simultaneous drain and accept, SHALL keep out_valid=1 and load the new result, with no bubble.
REQ-021 While out_valid && !out_ready, SHALL hold out_result, out_flags and out_valid stable, and in_ready SHALL be 0.
REQ-022 On accept with in_set_flags=1, SHALL load flags_q with the alu flags; otherwise flags_q SHALL hold.
REQ-023 SHALL never change state when in_valid=0, except by drain.
REQ-024 SHALL increment op_count by 1 on each accept, wrapping from 16'hFFFF to 0.
REQ-025 SHALL pass the alu flag vector unmodified, keeping the alu bit order.

Reset
REQ-026 While reset=1, SHALL force out_valid=0, out_result=0, out_flags=0, flags_q=0, op_count=0, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard any undrained result; in_ready SHALL read 1 while reset is held.
REQ-028 The first accept after reset deassertion SHALL behave identically to REQ-018.

Configuration
REQ-029 Macro ALU_EXEC_FWD_EN, when defined, SHALL add inputs in_fwd_a and in_fwd_b, each 1 bit.
REQ-030 With ALU_EXEC_FWD_EN defined, in_fwd_a=1 SHALL substitute the current out_result register for in_op1 at the alu, and in_fwd_b=1 SHALL do the same for in_op2; the substitution applies regardless of out_valid.
REQ-031 Without ALU_EXEC_FWD_EN, the ports in_fwd_a and in_fwd_b SHALL NOT exist, and the alu SHALL always see in_op1/in_op2.

Structure
REQ-032 A shared package alu_pkg SHALL hold: the 3-bit alu_control typedef, the flag-vector width constant (4), and the op_count width constant (16).
REQ-033 SHALL instantiate exactly one existing alu sub-module (ports op1, op2, alu_control, flags, result); no other sub-modules.

Verification
REQ-034 Reset check: assert reset mid-run with out_valid=1 -> immediately out_valid=0, out_result=0, flags_q=0, op_count=0.
REQ-035 Single-op check: WIDTH=4, op1=4'b0111, op2=4'b0001, sweep in_alu_control 0..7 with out_ready=1 -> each out_result/out_flags matches a standalone alu with the same inputs, one cycle after accept.
REQ-036 Backpressure check: out_ready=0 for 3 cycles after accept of 4'b1101/4'b0111 -> in_ready=0 and outputs stable; raise out_ready with a new op valid -> back-to-back transfer, no bubble, op_count +2.
REQ-037 Flag commit check: accept op1=4'b0101, op2=4'b0101 with in_set_flags=1, then op1=4'b1111, op2=4'b0001 with in_set_flags=0 -> flags_q equals the flags of the first op only.
REQ-038 Counter wrap check: preload op_count to 16'hFFFF by 65535 accepts, then one more accept -> op_count=0.
REQ-039 With ALU_EXEC_FWD_EN: accept 4'b0001+4'b1111, then in_fwd_a=1 with in_op1=4'b0000 -> alu sees op1 equal to the previous out_result.
